// File: rtl/blake2_pkg.sv
// Shared BLAKE2 definitions used by the message block loader.
//
// Contents:
//   cmd_e       - beat command carried on cmd_i (CONF, START, DATA, LAST)
//   state_e     - loader state machine states
//   CFG_*_OFF   - byte offsets of the fields inside the CONF byte stream
package blake2_pkg;

  typedef enum logic [1:0] {
    CMD_CONF  = 2'd0,
    CMD_START = 2'd1,
    CMD_DATA  = 2'd2,
    CMD_LAST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_FILL = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // CONF stream layout: key length, digest length, then message length LE
  localparam int CFG_KK_OFF = 0;
  localparam int CFG_NN_OFF = 1;
  localparam int CFG_LL_OFF = 2;

endpackage

// File: rtl/cfg_capture.sv
// Captures the configuration fields from a stream of CONF beats.
//
// Ports:
//   clk, reset   - clock and asynchronous active-high reset
//   conf_acc_i   - an accepted CONF beat is on data_i this cycle
//   restart_i    - loader is not in CFG yet, so this beat restarts byte numbering
//   data_i       - beat bytes, byte 0 in bits [7:0]
//   kk_o, nn_o   - key length and digest length
//   ll_o         - message length, little-endian from the CONF stream
module cfg_capture
  import blake2_pkg::*;
#(
  parameter int BW  = 4,
  parameter int LLW = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              conf_acc_i,
  input  logic              restart_i,
  input  logic [8*BW-1:0]   data_i,
  output logic [7:0]        kk_o,
  output logic [7:0]        nn_o,
  output logic [LLW-1:0]    ll_o
);

  localparam int CFG_END = CFG_LL_OFF + LLW / 8;
  localparam int CW      = $clog2(CFG_END + BW + 1) + 1;

  logic [CW-1:0]  cidx_q, cidx_d, base;
  logic [7:0]     kk_q, kk_d, nn_q, nn_d;
  logic [LLW-1:0] ll_q, ll_d;

  // Each beat byte gets a running stream position; the position decides
  // which field it lands in. Bytes past the message length are dropped and
  // the counter saturates so it never wraps back onto kk/nn.
  always_comb begin
    kk_d   = kk_q;
    nn_d   = nn_q;
    ll_d   = ll_q;
    cidx_d = cidx_q;
    base   = restart_i ? '0 : cidx_q;
    if (conf_acc_i) begin
      for (int j = 0; j < BW; j++) begin
        if (int'(base) + j == CFG_KK_OFF) begin
          kk_d = data_i[8*j +: 8];
        end else if (int'(base) + j == CFG_NN_OFF) begin
          nn_d = data_i[8*j +: 8];
        end else if (int'(base) + j >= CFG_LL_OFF && int'(base) + j < CFG_END) begin
          ll_d[8*(int'(base) + j - CFG_LL_OFF) +: 8] = data_i[8*j +: 8];
        end
      end
      cidx_d = (int'(base) >= CFG_END) ? base : base + CW'(BW);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cidx_q <= '0;
      kk_q   <= '0;
      nn_q   <= '0;
      ll_q   <= '0;
    end else begin
      cidx_q <= cidx_d;
      kk_q   <= kk_d;
      nn_q   <= nn_d;
      ll_q   <= ll_d;
    end
  end

  assign kk_o = kk_q;
  assign nn_o = nn_q;
  assign ll_o = ll_q;

endmodule

// File: rtl/msg_block_loader.sv
// Packs a byte stream of BW-byte beats into BB-byte BLAKE2 message blocks.
//
// Ports:
//   clk, reset       - clock and asynchronous active-high reset
//   en_i             - slice enable, registered once before use
//   valid_i/ready_o  - beat handshake; cmd_i selects CONF/START/DATA/LAST
//   data_i, nbv_i    - beat bytes and valid byte count of a LAST beat
//   kk_o, nn_o, ll_o - captured configuration
//   blk_v_o/blk_ready_i - block handshake; blk_o holds the zero-padded block
//   blk_first_o, blk_last_o, t_o - block flags and byte count through block
//   err_o            - sticky protocol error, cleared by a CONF beat
module msg_block_loader
  import blake2_pkg::*;
#(
  parameter int BW  = 4,
  parameter int BB  = 64,
  parameter int LLW = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [1:0]           cmd_i,
  input  logic [8*BW-1:0]      data_i,
  input  logic [$clog2(BW):0]  nbv_i,
  output logic [7:0]           kk_o,
  output logic [7:0]           nn_o,
  output logic [LLW-1:0]       ll_o,
  output logic                 blk_v_o,
  input  logic                 blk_ready_i,
  output logic [8*BB-1:0]      blk_o,
  output logic                 blk_first_o,
  output logic                 blk_last_o,
  output logic [LLW-1:0]       t_o,
  output logic                 err_o
);

  localparam int IW = $clog2(BB) + 1;
  localparam int NW = $clog2(BW) + 1;

  state_e         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d, idx_nxt;
  logic [LLW-1:0] t_q, t_d, t_base;
  logic [8*BB-1:0] blk_q, blk_d;
  logic           en_q;
  logic           first_q, first_d, last_q, last_d;
  logic           err_q, err_d, blk_v_q, blk_v_d;
  logic [NW-1:0]  nbytes;
  cmd_e           cmd;
  logic           acc, conf_acc, wr_en, msg_start, nbv_bad, overflow;

  assign cmd      = cmd_e'(cmd_i);
  assign ready_o  = en_q & (state_q != ST_HOLD);
  assign acc      = valid_i & ready_o;
  assign conf_acc = acc & (cmd == CMD_CONF);
  assign nbv_bad  = (nbv_i > NW'(BW));

  // An oversized nbv_i is flagged and the beat is treated as a full beat so
  // the write can never run past the beat or the buffer.
  assign nbytes   = (cmd == CMD_LAST && !nbv_bad) ? nbv_i : NW'(BW);
  assign idx_nxt  = idx_q + IW'(nbytes);
  assign overflow = ({1'b0, idx_q} + (IW+1)'(nbytes)) > (IW+1)'(BB);

  cfg_capture #(
    .BW  (BW),
    .LLW (LLW)
  ) u_cfg (
    .clk        (clk),
    .reset      (reset),
    .conf_acc_i (conf_acc),
    .restart_i  (state_q != ST_CFG),
    .data_i     (data_i),
    .kk_o       (kk_o),
    .nn_o       (nn_o),
    .ll_o       (ll_o)
  );

  // Next-state logic. A beat arriving straight out of CFG implicitly opens a
  // message, as does START at byte 0. The buffer is kept zeroed between
  // blocks, so unwritten bytes of a short block are already padding.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    t_d       = t_q;
    blk_d     = blk_q;
    first_d   = first_q;
    last_d    = last_q;
    err_d     = err_q;
    blk_v_d   = blk_v_q;
    wr_en     = 1'b0;
    msg_start = 1'b0;

    if (acc) begin
      unique case (cmd)
        CMD_CONF: begin
          state_d = ST_CFG;
          err_d   = 1'b0;
          if (state_q == ST_FILL) begin
            idx_d   = '0;
            blk_d   = '0;
            first_d = 1'b0;
          end
        end
        CMD_START: begin
          wr_en = 1'b1;
          if (idx_q == '0) msg_start = 1'b1;
          else             err_d     = 1'b1;
        end
        default: begin
          if (state_q == ST_IDLE) begin
            err_d = 1'b1;
          end else begin
            wr_en     = 1'b1;
            msg_start = (state_q == ST_CFG);
          end
        end
      endcase
    end

    t_base = msg_start ? '0 : t_q;

    if (wr_en) begin
      for (int j = 0; j < BW; j++) begin
        if (j < int'(nbytes) && int'(idx_q) + j < BB) begin
          blk_d[8*(int'(idx_q) + j) +: 8] = data_i[8*j +: 8];
        end
      end
      if (msg_start) first_d = 1'b1;
      if (cmd == CMD_LAST && (nbv_bad || overflow)) err_d = 1'b1;
      t_d     = t_base + LLW'(nbytes);
      idx_d   = idx_nxt;
      state_d = ST_FILL;
      if (cmd == CMD_LAST || idx_nxt >= IW'(BB)) begin
        state_d = ST_HOLD;
        blk_v_d = 1'b1;
        last_d  = (cmd == CMD_LAST);
      end
    end

    if (state_q == ST_HOLD && blk_ready_i) begin
      state_d = last_q ? ST_IDLE : ST_FILL;
      idx_d   = '0;
      blk_d   = '0;
      first_d = 1'b0;
      last_d  = 1'b0;
      blk_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q    <= 1'b0;
      state_q <= ST_IDLE;
      idx_q   <= '0;
      t_q     <= '0;
      blk_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      blk_v_q <= 1'b0;
    end else begin
      en_q    <= en_i;
      state_q <= state_d;
      idx_q   <= idx_d;
      t_q     <= t_d;
      blk_q   <= blk_d;
      first_q <= first_d;
      last_q  <= last_d;
      err_q   <= err_d;
      blk_v_q <= blk_v_d;
    end
  end

  assign blk_v_o     = blk_v_q;
  assign blk_o       = blk_q;
  assign blk_first_o = first_q;
  assign blk_last_o  = last_q;
  assign t_o         = t_q;
  assign err_o       = err_q;

endmodule

// File: doc/msg_block_loader.md
MSG_BLOCK_LOADER -- requirements
Module: msg_block_loader

Interface
REQ-001 SHALL have parameter BW, default 4, bytes per input beat; legal values 1, 2, 4, 8.
REQ-002 SHALL have parameter BB, default 64, message block bytes; 64 for BLAKE2s, 128 for BLAKE2b; BB is a multiple of BW.
REQ-003 SHALL have parameter LLW, default 64, width in bits of ll_o and t_o; a multiple of 8.
REQ-004 SHALL have port clk, input, 1 bit, the single clock.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-006 SHALL have port en_i, input, 1 bit, project slice enable; registered once before use.
REQ-007 SHALL have port valid_i, input, 1 bit, input beat valid.
REQ-008 SHALL have port ready_o, output, 1 bit, beat accepted when valid_i & ready_o.
REQ-009 SHALL have port cmd_i, input, 2 bits: 0 CONF, 1 START, 2 DATA, 3 LAST.
REQ-010 SHALL have port data_i, input, 8*BW bits, beat bytes, byte 0 in bits [7:0].
REQ-011 SHALL have port nbv_i, input, clog2(BW)+1 bits, valid byte count of a LAST beat; ignored otherwise.
REQ-012 SHALL have ports kk_o (8b), nn_o (8b), ll_o (LLW), all outputs, config key length, digest length and message length.
REQ-013 SHALL have ports blk_v_o (out, 1b), blk_ready_i (in, 1b), blk_o (out, 8*BB bits), blk_first_o (out, 1b), blk_last_o (out, 1b), t_o (out, LLW bits).
REQ-014 SHALL have port err_o, output, 1 bit, sticky protocol error.

Function
REQ-015 SHALL qualify every beat with en_q & valid_i & ready_o; ready_o = en_q & (state != HOLD).
REQ-016 SHALL implement FSM IDLE, CFG, FILL, HOLD.
REQ-017 SHALL go IDLE/FILL->CFG on an accepted CONF beat; CFG stays CFG on CONF; any accepted non-CONF beat leaves CFG.
REQ-018 SHALL number CONF bytes with a running index (reset on entry to CFG): byte 0->kk_o, byte 1->nn_o, bytes 2..LLW/8+1->ll_o little-endian; later bytes are ignored.
REQ-019 SHALL write accepted START/DATA/LAST bytes into the block buffer at byte index idx..idx+BW-1 (LAST: nbv_i bytes only), then advance idx.
REQ-020 SHALL, on a START beat at idx 0, set blk_first for the block and clear t to 0; START at idx != 0 sets err_o.
REQ-021 SHALL enter HOLD the cycle after the accepted beat that fills idx to BB, or after any accepted LAST beat.
REQ-022 SHALL zero-fill every buffer byte not written in the current block, including the empty message (LAST, nbv_i=0, idx 0).
REQ-023 SHALL in HOLD assert blk_v_o, keep blk_o, blk_first_o, blk_last_o, t_o stable until blk_v_o & blk_ready_i, then go to FILL (or IDLE after a last block) with idx=0, buffer zeroed, blk_first cleared.
REQ-024 SHALL present t_o = total message bytes through the held block (LLW-bit, wraps modulo 2^LLW).
REQ-025 SHALL set err_o on nbv_i > BW, on LAST with nbv_i overflowing idx past BB, or on DATA/LAST in IDLE without a preceding START; err_o clears only on an accepted CONF beat or reset.
REQ-026 SHALL latch blk_last_o only for a block closed by LAST; a full block closed by DATA has blk_last_o=0.

Reset
REQ-027 SHALL on reset asynchronously clear state to IDLE, idx, t, en_q, kk_o, nn_o, ll_o, blk_o, blk_v_o, blk_first_o, blk_last_o, err_o to 0; ready_o=0 until en_q=1.
REQ-028 SHALL on reset mid-HOLD drop blk_v_o immediately and discard the block.

Structure
REQ-029 SHALL place cmd encodings, the FSM state enum and the config byte offsets in the shared blake2 package.
REQ-030 SHALL split config capture into sub-module cfg_capture; block buffer and FSM remain in msg_block_loader.

Verification
REQ-031 SHALL cover: CONF beat 0x00000000_40_20 (BW=4 bytes 20,40,00,00) then 0 ll bytes -> kk_o=0x20, nn_o=0x40, ll_o=0.
REQ-032 SHALL cover: START + 15 DATA beats, BW=4, BB=64 -> blk_v_o one cycle after 16th beat, blk_first_o=1, blk_last_o=0, t_o=64, ready_o=0 until blk_ready_i.
REQ-033 SHALL cover: START + LAST nbv_i=3 data 0xAABBCCDD -> blk_o bytes 0..6 valid, byte 7 = 0x00, bytes 8..63 = 0, t_o=7, blk_first_o=blk_last_o=1.
REQ-034 SHALL cover: empty message, START nbv 0 via LAST at idx 0 -> one all-zero block, t_o=0, blk_last_o=1.
REQ-035 SHALL cover: blk_ready_i held low 10 cycles with valid_i high -> no beat accepted, blk_o unchanged.
REQ-036 SHALL cover: reset asserted mid-FILL and mid-HOLD -> all outputs 0 same cycle, DATA afterwards sets err_o.
